// File: rtl/tlb_port_arb.sv
// Arbitrates instruction and data translation requests onto one shared TLB search port.
// One transaction in flight: accept in IDLE, translate in LOOKUP, hold the response in RESP.
module tlb_port_arb #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,

  input  logic        inst_req,
  input  logic [31:0] inst_vaddr,
  output logic        inst_addr_ok,
  output logic        inst_rsp_valid,
  input  logic        inst_rsp_ready,
  output logic [31:0] inst_paddr,
  output logic [4:0]  inst_excode,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_vaddr,
  output logic        data_addr_ok,
  output logic        data_rsp_valid,
  input  logic        data_rsp_ready,
  output logic [31:0] data_paddr,
  output logic [4:0]  data_excode,

  output logic [18:0] s0_vpn2,
  output logic        s0_odd_page,
  input  logic        s0_found,
  input  logic [19:0] s0_pfn,
  input  logic        s0_d,
  input  logic        s0_v
);

  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StLookup, StResp} state_e;

  state_e          state_q;
  logic [CntW-1:0] starve_q;
  logic [31:0]     vaddr_q;
  logic            wr_q;
  logic            owner_q;  // 1 = data channel owns the transaction
  logic [31:0]     paddr_q;
  logic [4:0]      excode_q;

  logic        idle_open;
  logic        starved;
  logic        grant_inst;
  logic        grant_data;
  logic        owner_ready;
  logic        unmapped;
  logic [31:0] xlat_paddr;
  logic [4:0]  xlat_excode;

  always_comb begin
    idle_open   = (state_q == StIdle) && !flush && !reset;
    starved     = (starve_q == CntW'(STARVE_LIMIT));
    grant_inst  = idle_open && inst_req && (starved || !data_req);
    grant_data  = idle_open && data_req && !grant_inst;
    owner_ready = owner_q ? data_rsp_ready : inst_rsp_ready;
  end

  // Unmapped window is vaddr[31:28] in 8..C; the TLB result is ignored there.
  always_comb begin
    unmapped    = vaddr_q[31] && (vaddr_q[30:28] <= 3'b100);
    xlat_paddr  = {s0_pfn, vaddr_q[11:0]};
    xlat_excode = 5'b11111;
    if (unmapped) begin
      xlat_paddr = vaddr_q;
    end else if (!s0_found || !s0_v) begin
      xlat_excode = wr_q ? 5'b00011 : 5'b00010;
    end else if (wr_q && !s0_d) begin
      xlat_excode = 5'b00001;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      starve_q <= '0;
      vaddr_q  <= '0;
      wr_q     <= 1'b0;
      owner_q  <= 1'b0;
      paddr_q  <= '0;
      excode_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Flush freezes the starvation counter along with the grant.
          if (!flush) begin
            if (grant_inst || !inst_req) begin
              starve_q <= '0;
            end else if (grant_data && !starved) begin
              starve_q <= starve_q + 1'b1;
            end
            if (grant_inst || grant_data) begin
              vaddr_q <= grant_data ? data_vaddr : inst_vaddr;
              wr_q    <= grant_data && data_wr;
              owner_q <= grant_data;
              state_q <= StLookup;
            end
          end
        end
        StLookup: begin
          if (flush) begin
            state_q <= StIdle;
          end else begin
            paddr_q  <= xlat_paddr;
            excode_q <= xlat_excode;
            state_q  <= StResp;
          end
        end
        StResp: begin
          if (flush || owner_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    inst_addr_ok   = grant_inst;
    data_addr_ok   = grant_data;
    inst_rsp_valid = (state_q == StResp) && !owner_q;
    data_rsp_valid = (state_q == StResp) && owner_q;
    inst_paddr     = paddr_q;
    inst_excode    = excode_q;
    data_paddr     = paddr_q;
    data_excode    = excode_q;
    s0_vpn2        = vaddr_q[31:13];
    s0_odd_page    = vaddr_q[12];
  end

endmodule

// File: tb/tb_tlb_port_arb.sv
// Self-checking bench for tlb_port_arb: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_tlb_port_arb;

  localparam int unsigned Limit = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        inst_req, inst_addr_ok, inst_rsp_valid, inst_rsp_ready;
  logic [31:0] inst_vaddr, inst_paddr;
  logic [4:0]  inst_excode;
  logic        data_req, data_wr, data_addr_ok, data_rsp_valid, data_rsp_ready;
  logic [31:0] data_vaddr, data_paddr;
  logic [4:0]  data_excode;
  logic [18:0] s0_vpn2;
  logic        s0_odd_page, s0_found, s0_d, s0_v;
  logic [19:0] s0_pfn;

  int n_checks = 0;
  int n_fail   = 0;

  tlb_port_arb #(.STARVE_LIMIT(Limit)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_addr_ok(inst_addr_ok),
    .inst_rsp_valid(inst_rsp_valid), .inst_rsp_ready(inst_rsp_ready),
    .inst_paddr(inst_paddr), .inst_excode(inst_excode),
    .data_req(data_req), .data_wr(data_wr), .data_vaddr(data_vaddr),
    .data_addr_ok(data_addr_ok), .data_rsp_valid(data_rsp_valid),
    .data_rsp_ready(data_rsp_ready), .data_paddr(data_paddr), .data_excode(data_excode),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_found(s0_found),
    .s0_pfn(s0_pfn), .s0_d(s0_d), .s0_v(s0_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_busy;
  int          m_acc;
  int          cyc = 0;
  bit          m_own_data;
  logic [31:0] m_va;
  bit          m_wr;
  logic [31:0] m_pa;
  logic [4:0]  m_ex;
  int          m_starve;

  always @(negedge clk) begin
    bit g_i, g_d, in_resp;
    if (reset) begin
      chk("rst_inst_addr_ok", inst_addr_ok, 0);
      chk("rst_data_addr_ok", data_addr_ok, 0);
      chk("rst_rsp_valid", {inst_rsp_valid, data_rsp_valid}, 0);
      chk("rst_paddr", inst_paddr | data_paddr, 0);
      chk("rst_excode", inst_excode | data_excode, 0);
      chk("rst_s0", {s0_vpn2, s0_odd_page}, 0);
      m_busy = 0; m_va = 0; m_wr = 0; m_own_data = 0;
      m_pa = 0; m_ex = 0; m_starve = 0;
    end else begin
      g_i = 0; g_d = 0;
      if (!m_busy && !flush) begin
        if (inst_req && (m_starve == Limit || !data_req)) g_i = 1;
        else if (data_req) g_d = 1;
      end
      in_resp = m_busy && (cyc - m_acc >= 2);
      chk("m_inst_addr_ok", inst_addr_ok, g_i);
      chk("m_data_addr_ok", data_addr_ok, g_d);
      chk("m_inst_rsp_valid", inst_rsp_valid, in_resp && !m_own_data);
      chk("m_data_rsp_valid", data_rsp_valid, in_resp && m_own_data);
      chk("m_inst_paddr", inst_paddr, m_pa);
      chk("m_data_paddr", data_paddr, m_pa);
      chk("m_inst_excode", inst_excode, m_ex);
      chk("m_data_excode", data_excode, m_ex);
      chk("m_s0_vpn2", s0_vpn2, m_va >> 13);
      chk("m_s0_odd", s0_odd_page, (m_va >> 12) & 1);
      if (!m_busy) begin
        if (!flush) begin
          if (g_i || !inst_req) m_starve = 0;
          else if (m_starve < Limit) m_starve++;
          if (g_i || g_d) begin
            m_busy = 1; m_acc = cyc; m_own_data = g_d;
            m_va = g_d ? data_vaddr : inst_vaddr;
            m_wr = g_d && data_wr;
          end
        end
      end else if (flush) begin
        m_busy = 0;
      end else if (cyc - m_acc == 1) begin
        if (m_va >= 32'h8000_0000 && m_va < 32'hD000_0000) begin
          m_pa = m_va; m_ex = 5'd31;
        end else begin
          m_pa = (32'(s0_pfn) << 12) + (m_va % 4096);
          if (!s0_found || !s0_v) m_ex = m_wr ? 5'd3 : 5'd2;
          else if (m_wr && !s0_d) m_ex = 5'd1;
          else m_ex = 5'd31;
        end
      end else if (m_own_data ? data_rsp_ready : inst_rsp_ready) begin
        m_busy = 0;
      end
    end
    cyc++;
  end

  // ---------------- directed helpers ----------------
  task automatic do_xact(input bit is_data, input bit wr, input logic [31:0] va,
                         input bit found, input bit v, input bit d, input logic [19:0] pfn,
                         output logic [31:0] pa, output logic [4:0] ex);
    inst_rsp_ready = 1; data_rsp_ready = 1;
    s0_found = found; s0_v = v; s0_d = d; s0_pfn = pfn;
    if (is_data) begin data_req = 1; data_wr = wr; data_vaddr = va; end
    else begin inst_req = 1; inst_vaddr = va; end
    @(negedge clk);
    chk("xact_addr_ok_cycle0", is_data ? data_addr_ok : inst_addr_ok, 1);
    @(posedge clk); #1;
    inst_req = 0; data_req = 0;
    @(negedge clk);
    chk("xact_lookup_no_valid", {inst_rsp_valid, data_rsp_valid}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("xact_rsp_valid_cycle2", is_data ? data_rsp_valid : inst_rsp_valid, 1);
    pa = is_data ? data_paddr : inst_paddr;
    ex = is_data ? data_excode : inst_excode;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_va();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: return r;
      1: return {4'h8, r[27:0]};
      2: return {4'hC, r[27:0]};
      3: return {4'hD, r[27:0]};
      default: return {4'h0, r[27:0]};
    endcase
  endfunction

  initial begin
    logic [31:0] pa;
    logic [4:0]  ex;
    logic [7:0]  order;
    int          ngr;
    reset = 1; flush = 0;
    inst_req = 0; inst_vaddr = 0; inst_rsp_ready = 0;
    data_req = 0; data_wr = 0; data_vaddr = 0; data_rsp_ready = 0;
    s0_found = 0; s0_pfn = 0; s0_d = 0; s0_v = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset = 0;

    do_xact(0, 0, 32'hBFC0_0000, 0, 0, 0, 20'hABCDE, pa, ex);
    chk("fetch_unmapped_paddr", pa, 32'hBFC0_0000);
    chk("fetch_unmapped_excode", ex, 5'b11111);
    do_xact(1, 0, 32'h0040_1234, 1, 1, 0, 20'h12345, pa, ex);
    chk("load_mapped_paddr", pa, 32'h1234_5234);
    chk("load_mapped_excode", ex, 5'b11111);
    do_xact(1, 1, 32'h0040_2000, 1, 1, 0, 20'h00777, pa, ex);
    chk("store_not_dirty_excode", ex, 5'b00001);
    chk("store_not_dirty_paddr", pa, 32'h0077_7000);
    do_xact(1, 1, 32'h0040_2000, 0, 1, 1, 20'h00777, pa, ex);
    chk("store_miss_excode", ex, 5'b00011);
    do_xact(1, 0, 32'h0040_2000, 1, 0, 1, 20'h00777, pa, ex);
    chk("load_invalid_excode", ex, 5'b00010);

    // Both requesters held high: expect D,D,D,I,D,D,D,I.
    inst_req = 1; data_req = 1; data_wr = 0;
    inst_vaddr = 32'h0000_1000; data_vaddr = 32'h0000_2000;
    order = 0; ngr = 0;
    for (int i = 0; i < 40 && ngr < 8; i++) begin
      @(negedge clk);
      if (inst_addr_ok || data_addr_ok) begin
        order = {order[6:0], data_addr_ok};
        ngr++;
      end
    end
    chk("starve_grant_count", ngr, 8);
    chk("starve_grant_order", order, 8'b1110_1110);
    @(posedge clk); #1;
    inst_req = 0; data_req = 0;
    repeat (3) @(posedge clk);
    #1;

    // Flush during LOOKUP cancels; pending inst granted in the following IDLE cycle.
    data_req = 1; data_vaddr = 32'h0040_3000;
    @(negedge clk);
    chk("flush_first_grant", data_addr_ok, 1);
    @(posedge clk); #1;
    data_req = 0; inst_req = 1; inst_vaddr = 32'hBFC0_0010; flush = 1;
    @(negedge clk);
    chk("flush_lookup_no_valid", {inst_rsp_valid, data_rsp_valid}, 0);
    chk("flush_lookup_no_addr_ok", inst_addr_ok, 0);
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    chk("flush_then_grant_inst", inst_addr_ok, 1);
    chk("flush_no_response", {inst_rsp_valid, data_rsp_valid}, 0);
    @(posedge clk); #1;
    inst_req = 0;
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure for 5 cycles, then asynchronous reset mid-response.
    data_rsp_ready = 0; inst_rsp_ready = 0;
    data_req = 1; data_wr = 0; data_vaddr = 32'h9000_0040;
    @(negedge clk);
    chk("stall_accept", data_addr_ok, 1);
    @(posedge clk); #1;
    data_req = 0; inst_req = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", data_rsp_valid, 1);
      chk("stall_paddr", data_paddr, 32'h9000_0040);
      chk("stall_excode", data_excode, 5'b11111);
      chk("stall_no_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    end
    @(posedge clk); #3;
    reset = 1;
    #1;
    chk("async_rst_valid", {inst_rsp_valid, data_rsp_valid}, 0);
    chk("async_rst_paddr", data_paddr, 0);
    chk("async_rst_excode", data_excode, 0);
    chk("async_rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    chk("async_rst_vpn2", s0_vpn2, 0);
    @(posedge clk); #1;
    reset = 0; inst_req = 0;

    // Randomized traffic; the model process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      flush = ($urandom_range(0, 15) == 0);
      inst_req = inst_req ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) < 2);
      data_req = data_req ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) < 2);
      inst_vaddr = pick_va();
      data_vaddr = pick_va();
      data_wr = $urandom_range(0, 1);
      inst_rsp_ready = ($urandom_range(0, 9) < 7);
      data_rsp_ready = ($urandom_range(0, 9) < 7);
      s0_found = ($urandom_range(0, 3) != 0);
      s0_v = ($urandom_range(0, 3) != 0);
      s0_d = $urandom_range(0, 1);
      s0_pfn = 20'($urandom);
      @(posedge clk); #1;
    end
    reset = 0; flush = 0; inst_req = 0; data_req = 0;
    inst_rsp_ready = 1; data_rsp_ready = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
